// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer for a single-ported combinational
// instruction memory. Owns the fetch PC and captures each returned word into
// a 2-entry buffer. The word is tagged with its PC and any fetch fault. The
// buffer is drained by decode over a valid/ready handshake. After a fault is
// captured, fetch halts until a redirect restarts it.
module ifetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    // First byte address past the end of instruction memory.
    localparam logic [63:0] PC_LIMIT  = 64'(MEM_WORDS) * 64'd4;
    localparam logic [3:0]  EXC_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_ACCESS     = 4'd1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;

    // Buffer bookkeeping: read/write slot pointers and occupancy (0..2).
    logic       rd_q, wr_q;
    logic [1:0] count_q, count_d;

    // Buffer storage, one slot per entry.
    logic [63:0] ent_pc    [2];
    logic [31:0] ent_instr [2];
    logic        ent_exc   [2];
    logic [3:0]  ent_code  [2];

    logic        pop;
    logic        issue;
    logic        fault;
    logic [3:0]  fault_code;
    logic [1:0]  count_after_pop;

    assign imem_addr = pc_q;

    assign pop             = out_valid & out_ready;
    assign count_after_pop = count_q - {1'b0, pop};
    assign issue           = (state_q == RUN) & ~redirect_en & (count_after_pop < 2'd2);

    // Fault classification for the current PC; misalignment takes priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and a latch is never inferred.
        fault      = 1'b0;
        fault_code = EXC_MISALIGNED;
        if (pc_q[1:0] != 2'b00) begin
            fault      = 1'b1;
            fault_code = EXC_MISALIGNED;
        end else if (pc_q >= PC_LIMIT) begin
            fault      = 1'b1;
            fault_code = EXC_ACCESS;
        end
    end

    // State and PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and next PC: redirect wins, then issue; a faulting issue halts and holds the PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_en) begin
            state_d = RUN;
            pc_d    = redirect_pc;
        end else if (issue) begin
            if (fault) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + 64'd4;
            end
        end
    end

    // Occupancy update: redirect flushes, otherwise pop and push net out.
    always_comb begin
        count_d = count_after_pop;
        if (redirect_en) begin
            count_d = 2'd0;
        end else if (issue) begin
            count_d = count_after_pop + 2'd1;
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
            if (redirect_en) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end else begin
                if (pop) begin
                    rd_q <= ~rd_q;
                end
                if (issue) begin
                    wr_q <= ~wr_q;
                end
            end
        end
    end

    // Capture the fetched word (or a NOP on a fault) into the tail slot.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the outputs are masked by occupancy, so stale slot contents are never visible.
        if (issue) begin
            ent_pc[wr_q]    <= pc_q;
            ent_instr[wr_q] <= fault ? NOP_INSTR : imem_instr;
            ent_exc[wr_q]   <= fault;
            ent_code[wr_q]  <= fault ? fault_code : 4'd0;
        end
    end

    // Head presentation; idle values are shown when the buffer is empty.
    always_comb begin
        out_valid    = (count_q != 2'd0);
        out_instr    = NOP_INSTR;
        out_pc       = 64'd0;
        out_exc_en   = 1'b0;
        out_exc_code = 4'd0;
        out_exc_val  = 64'd0;
        if (out_valid) begin
            out_instr    = ent_instr[rd_q];
            out_pc       = ent_pc[rd_q];
            out_exc_en   = ent_exc[rd_q];
            out_exc_code = ent_code[rd_q];
            out_exc_val  = ent_exc[rd_q] ? ent_pc[rd_q] : 64'd0;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed, table-driven bench for ifetch_ctrl. The memory
// model returns the low 32 bits of the fetch address as the instruction word.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;

    int total;
    int bad;

    ifetch_ctrl #(
        .RESET_PC (64'h0),
        .MEM_WORDS(2048)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_exc_en  (out_exc_en),
        .out_exc_code(out_exc_code),
        .out_exc_val (out_exc_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory model.
    assign imem_instr = imem_addr[31:0];

    typedef struct {
        logic        rd_en;
        logic [63:0] rd_pc;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_addr;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_exc;
        logic [3:0]  e_code;
        logic [63:0] e_val;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk_idle(logic [63:0] addr, logic rdy, logic rd_en, logic [63:0] rd_pc);
        vec_t v;
        v.rd_en   = rd_en;
        v.rd_pc   = rd_pc;
        v.rdy     = rdy;
        v.e_valid = 1'b0;
        v.e_addr  = addr;
        v.e_pc    = 64'd0;
        v.e_instr = 32'h13;
        v.e_exc   = 1'b0;
        v.e_code  = 4'd0;
        v.e_val   = 64'd0;
        return v;
    endfunction

    function automatic vec_t mk_ok(logic [63:0] addr, logic [63:0] pc, logic rdy, logic rd_en, logic [63:0] rd_pc);
        vec_t v;
        v = mk_idle(addr, rdy, rd_en, rd_pc);
        v.e_valid = 1'b1;
        v.e_pc    = pc;
        v.e_instr = pc[31:0];
        return v;
    endfunction

    function automatic vec_t mk_exc(logic [63:0] addr, logic [63:0] pc, logic [3:0] code, logic rdy);
        vec_t v;
        v = mk_idle(addr, rdy, 1'b0, 64'd0);
        v.e_valid = 1'b1;
        v.e_pc    = pc;
        v.e_instr = 32'h13;
        v.e_exc   = 1'b1;
        v.e_code  = code;
        v.e_val   = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " valid"}, 64'(out_valid), 64'(v.e_valid));
        check({tag, " addr"},  imem_addr, v.e_addr);
        check({tag, " pc"},    out_pc, v.e_pc);
        check({tag, " instr"}, 64'(out_instr), 64'(v.e_instr));
        check({tag, " exc"},   64'(out_exc_en), 64'(v.e_exc));
        check({tag, " code"},  64'(out_exc_code), 64'(v.e_code));
        check({tag, " val"},   out_exc_val, v.e_val);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 64'd0;
        out_ready   = 1'b0;

        // Each vector: outputs expected in this cycle, then inputs held across the next edge.
        // Backpressure from PC 0: the buffer fills with 0 and 4, and the address holds at 8.
        vecs.push_back(mk_idle(64'h0,            1'b0, 1'b0, 64'h0));      // 0
        vecs.push_back(mk_ok(64'h4,  64'h0,      1'b0, 1'b0, 64'h0));      // 1
        vecs.push_back(mk_ok(64'h8,  64'h0,      1'b0, 1'b0, 64'h0));      // 2
        vecs.push_back(mk_ok(64'h8,  64'h0,      1'b0, 1'b0, 64'h0));      // 3
        vecs.push_back(mk_ok(64'h8,  64'h0,      1'b0, 1'b0, 64'h0));      // 4
        vecs.push_back(mk_ok(64'h8,  64'h0,      1'b1, 1'b0, 64'h0));      // 5 release
        vecs.push_back(mk_ok(64'hC,  64'h4,      1'b1, 1'b0, 64'h0));      // 6
        vecs.push_back(mk_ok(64'h10, 64'h8,      1'b1, 1'b0, 64'h0));      // 7
        vecs.push_back(mk_ok(64'h14, 64'hC,      1'b0, 1'b0, 64'h0));      // 8 stall, full
        // Redirect while the buffer is full.
        vecs.push_back(mk_ok(64'h14, 64'hC,      1'b0, 1'b1, 64'h100));    // 9
        vecs.push_back(mk_idle(64'h100,          1'b1, 1'b0, 64'h0));      // 10
        vecs.push_back(mk_ok(64'h104, 64'h100,   1'b1, 1'b0, 64'h0));      // 11
        // Misaligned redirect: a single code-0 entry, then halt.
        vecs.push_back(mk_ok(64'h108, 64'h104,   1'b1, 1'b1, 64'h102));    // 12
        vecs.push_back(mk_idle(64'h102,          1'b1, 1'b0, 64'h0));      // 13
        vecs.push_back(mk_exc(64'h102, 64'h102, 4'd0, 1'b0));              // 14 held
        vecs.push_back(mk_exc(64'h102, 64'h102, 4'd0, 1'b1));              // 15 popped
        vecs.push_back(mk_idle(64'h102,          1'b1, 1'b0, 64'h0));      // 16 halted
        vecs.push_back(mk_idle(64'h102,          1'b1, 1'b1, 64'h1FF8));   // 17 halted
        // Access fault at the end of memory, then recovery.
        vecs.push_back(mk_idle(64'h1FF8,         1'b1, 1'b0, 64'h0));      // 18
        vecs.push_back(mk_ok(64'h1FFC, 64'h1FF8, 1'b1, 1'b0, 64'h0));      // 19
        vecs.push_back(mk_ok(64'h2000, 64'h1FFC, 1'b1, 1'b0, 64'h0));      // 20
        vecs.push_back(mk_exc(64'h2000, 64'h2000, 4'd1, 1'b1));            // 21
        vecs.push_back(mk_idle(64'h2000,         1'b1, 1'b0, 64'h0));      // 22 halted
        vecs.push_back(mk_idle(64'h2000,         1'b1, 1'b1, 64'h40));     // 23 halted
        vecs.push_back(mk_idle(64'h40,           1'b1, 1'b0, 64'h0));      // 24
        vecs.push_back(mk_ok(64'h44, 64'h40,     1'b1, 1'b0, 64'h0));      // 25

        // Reset state is checked before release.
        #2;
        check("reset valid", 64'(out_valid), 64'd0);
        check("reset addr", imem_addr, 64'h0);
        check("reset instr", 64'(out_instr), 64'h13);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i > 0) @(negedge clk);
            check_outputs($sformatf("v%0d", i), vecs[i]);
            redirect_en = vecs[i].rd_en;
            redirect_pc = vecs[i].rd_pc;
            out_ready   = vecs[i].rdy;
        end

        // Asynchronous reset between edges while an entry is valid.
        @(negedge clk);
        check("pre-areset valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset valid", 64'(out_valid), 64'd0);
        check("areset addr", imem_addr, 64'h0);
        check("areset pc", out_pc, 64'h0);
        check("areset instr", 64'(out_instr), 64'h13);

        // Release and stream with no backpressure: 0, 4, 8, 12 on consecutive cycles.
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        begin
            int waited;
            waited = 0;
            while (!out_valid && waited < 5) begin
                @(negedge clk);
                waited++;
            end
            check("first valid latency", 64'(waited), 64'd1);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stream%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d pc", k), out_pc, 64'(4 * k));
            check($sformatf("stream%0d instr", k), 64'(out_instr), 64'(4 * k));
            check($sformatf("stream%0d exc", k), 64'(out_exc_en), 64'd0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
